// File: rtl/fpu_pkg.sv
// Shared FPU constants and the align-stage state encoding.
// Operand field widths, aligned datapath width and special-exponent helper.
package fpu_pkg;

    localparam int FPU_EXP_W = 5;
    localparam int FPU_MAN_W = 10;
    localparam int GRS_W     = 3;
    localparam int FPU_DW    = FPU_MAN_W + 1 + GRS_W;

    // An exponent field of all ones marks Inf/NaN
    localparam logic [FPU_EXP_W-1:0] EXP_ONES = {FPU_EXP_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_SHIFT,
        S_ISSUE,
        S_WAIT
    } align_state_t;

endpackage

// File: rtl/sticky_right_shifter.sv
// Combinational right shift by 0..2^AMT_W-1 bits; every bit shifted out is
// ORed into the result LSB so rounding still sees it.
module sticky_right_shifter #(
    parameter int W     = 14,
    parameter int AMT_W = 3
) (
    input  logic [W-1:0]     i_data,
    input  logic [AMT_W-1:0] i_amt,
    output logic [W-1:0]     o_data
);

    logic [W-1:0] w_mask;
    logic [W-1:0] w_shifted;
    logic         w_sticky;

    assign w_mask    = ~({W{1'b1}} << i_amt);
    assign w_shifted = i_data >> i_amt;
    assign w_sticky  = |(i_data & w_mask);
    assign o_data    = {w_shifted[W-1:1], w_shifted[0] | w_sticky};

endmodule

// File: rtl/fp_align_stage.sv
// FPU add-path front end: unpack, order by magnitude, align the smaller
// mantissa with a multi-cycle sticky shift, then hand one start pulse to the adder.
module fp_align_stage
    import fpu_pkg::*;
#(
    parameter int EXP_W      = FPU_EXP_W,
    parameter int MAN_W      = FPU_MAN_W,
    parameter int SHIFT_STEP = 4
) (
    input  logic                   CLOCK_50,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   op_a,
    input  logic [EXP_W+MAN_W:0]   op_b,
    input  logic                   op_sub,
    output logic                   add_start,
    output logic [MAN_W+3:0]       add_A,
    output logic [MAN_W+3:0]       add_B,
    output logic                   add_Cin,
    input  logic                   adder_done,
    output logic                   res_sign,
    output logic [EXP_W-1:0]       res_exp,
    output logic                   eff_sub,
    output logic                   special
);

    localparam int DW    = MAN_W + 4;
    localparam int AMT_W = $clog2(SHIFT_STEP + 1);

    align_state_t          r_state;
    logic [EXP_W+MAN_W:0]  r_opA, r_opB;
    logic                  r_opSub;
    logic [DW-1:0]         r_manL, r_manS;
    logic [EXP_W-1:0]      r_remain;

    logic [EXP_W-1:0] w_expFieldA, w_expFieldB, w_expA, w_expB, w_expL, w_expS, w_diff;
    logic [DW-1:0]    w_manA, w_manB, w_manL, w_manS, w_manHuge, w_shiftOut;
    logic             w_signA, w_signB, w_signL, w_aIsLarger, w_tie, w_effSub, w_special;
    logic [AMT_W-1:0] w_shiftAmt;
    logic [EXP_W-1:0] w_remainNext;

    // Denormals (exp field 0) behave as exponent 1 with no hidden bit
    assign w_expFieldA = r_opA[EXP_W+MAN_W-1:MAN_W];
    assign w_expFieldB = r_opB[EXP_W+MAN_W-1:MAN_W];
    assign w_expA      = (w_expFieldA == '0) ? EXP_W'(1) : w_expFieldA;
    assign w_expB      = (w_expFieldB == '0) ? EXP_W'(1) : w_expFieldB;
    assign w_manA      = {(w_expFieldA != '0), r_opA[MAN_W-1:0], {GRS_W{1'b0}}};
    assign w_manB      = {(w_expFieldB != '0), r_opB[MAN_W-1:0], {GRS_W{1'b0}}};
    assign w_signA     = r_opA[EXP_W+MAN_W];
    assign w_signB     = r_opB[EXP_W+MAN_W] ^ r_opSub;

    assign w_aIsLarger = (w_expA > w_expB) || ((w_expA == w_expB) && (w_manA >= w_manB));
    assign w_tie       = (w_expA == w_expB) && (w_manA == w_manB);
    assign w_expL      = w_aIsLarger ? w_expA : w_expB;
    assign w_expS      = w_aIsLarger ? w_expB : w_expA;
    assign w_manL      = w_aIsLarger ? w_manA : w_manB;
    assign w_manS      = w_aIsLarger ? w_manB : w_manA;
    assign w_signL     = w_aIsLarger ? w_signA : w_signB;
    assign w_diff      = w_expL - w_expS;
    assign w_effSub    = w_signA ^ w_signB;
    assign w_manHuge   = {{(DW-1){1'b0}}, |w_manS};
    assign w_special   = (w_expFieldA == EXP_ONES) || (w_expFieldB == EXP_ONES);

    assign w_shiftAmt   = (r_remain > EXP_W'(SHIFT_STEP)) ? AMT_W'(SHIFT_STEP) : AMT_W'(r_remain);
    assign w_remainNext = r_remain - EXP_W'(w_shiftAmt);

    assign in_ready = (r_state == S_IDLE);

    sticky_right_shifter #(
        .W     (DW),
        .AMT_W (AMT_W)
    ) u_shifter (
        .i_data (r_manS),
        .i_amt  (w_shiftAmt),
        .o_data (w_shiftOut)
    );

    // add_start is raised on the edge entering ISSUE, so it is high for exactly that state
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_opA     <= '0;
            r_opB     <= '0;
            r_opSub   <= 1'b0;
            r_manL    <= '0;
            r_manS    <= '0;
            r_remain  <= '0;
            add_start <= 1'b0;
            add_A     <= '0;
            add_B     <= '0;
            add_Cin   <= 1'b0;
            res_sign  <= 1'b0;
            res_exp   <= '0;
            eff_sub   <= 1'b0;
            special   <= 1'b0;
        end else begin
            add_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_opA   <= op_a;
                        r_opB   <= op_b;
                        r_opSub <= op_sub;
                        r_state <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    res_sign <= (w_tie && w_effSub) ? 1'b0 : w_signL;
                    res_exp  <= w_expL;
                    eff_sub  <= w_effSub;
                    special  <= w_special;
                    r_manL   <= w_manL;
                    if (w_diff == '0) begin
                        add_start <= 1'b1;
                        add_A     <= w_manL;
                        add_B     <= w_effSub ? ~w_manS : w_manS;
                        add_Cin   <= w_effSub;
                        r_state   <= S_ISSUE;
                    end else if (int'(w_diff) >= DW) begin
                        add_start <= 1'b1;
                        add_A     <= w_manL;
                        add_B     <= w_effSub ? ~w_manHuge : w_manHuge;
                        add_Cin   <= w_effSub;
                        r_state   <= S_ISSUE;
                    end else begin
                        r_manS   <= w_manS;
                        r_remain <= w_diff;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_manS   <= w_shiftOut;
                    r_remain <= w_remainNext;
                    if (w_remainNext == '0) begin
                        add_start <= 1'b1;
                        add_A     <= r_manL;
                        add_B     <= eff_sub ? ~w_shiftOut : w_shiftOut;
                        add_Cin   <= eff_sub;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (adder_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_align_stage.sv
// Directed-vector bench for fp_align_stage with hand-computed alignment results,
// issue latencies, WAIT-state handshake behaviour and mid-operation reset.
module tb_fp_align_stage;

    logic        CLOCK_50;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_sub;
    logic        add_start;
    logic [13:0] add_A;
    logic [13:0] add_B;
    logic        add_Cin;
    logic        adder_done;
    logic        res_sign;
    logic [4:0]  res_exp;
    logic        eff_sub;
    logic        special;

    int checkCount;
    int failCount;

    fp_align_stage dut (
        .CLOCK_50   (CLOCK_50),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_sub     (op_sub),
        .add_start  (add_start),
        .add_A      (add_A),
        .add_B      (add_B),
        .add_Cin    (add_Cin),
        .adder_done (adder_done),
        .res_sign   (res_sign),
        .res_exp    (res_exp),
        .eff_sub    (eff_sub),
        .special    (special)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // One full accept -> issue -> wait -> done handshake with expected alignment results
    task automatic applyStimulus(
        input logic [15:0] opA, input logic [15:0] opB, input logic sub,
        input int expLat, input logic [13:0] expA, input logic [13:0] expB,
        input logic expCin, input logic expSign, input logic [4:0] expExp,
        input logic expEff, input logic expSpecial, input logic pokeInWait
    );
        int lat;
        @(negedge CLOCK_50);
        checkOutput("readyBeforeAccept", in_ready, 1);
        in_valid = 1'b1;
        op_a     = opA;
        op_b     = opB;
        op_sub   = sub;
        @(posedge CLOCK_50);
        #1 in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLOCK_50);
            if (add_start) begin
                lat = i;
                break;
            end
        end
        checkOutput("startLatency", lat, expLat);
        checkOutput("addA", add_A, expA);
        checkOutput("addB", add_B, expB);
        checkOutput("addCin", add_Cin, expCin);
        checkOutput("resSign", res_sign, expSign);
        checkOutput("resExp", res_exp, expExp);
        checkOutput("effSub", eff_sub, expEff);
        checkOutput("special", special, expSpecial);
        @(negedge CLOCK_50);
        checkOutput("startOnePulse", add_start, 0);
        checkOutput("busyInWait", in_ready, 0);
        if (pokeInWait) begin
            in_valid = 1'b1;
            op_a     = 16'h3C00;
            op_b     = 16'h4000;
            op_sub   = 1'b1;
            @(posedge CLOCK_50);
            #1 in_valid = 1'b0;
            @(negedge CLOCK_50);
            checkOutput("noAcceptInWait", in_ready, 0);
            checkOutput("holdAddBInWait", add_B, expB);
            checkOutput("noStartInWait", add_start, 0);
        end
        adder_done = 1'b1;
        @(posedge CLOCK_50);
        #1 adder_done = 1'b0;
        @(negedge CLOCK_50);
        checkOutput("readyAfterDone", in_ready, 1);
        checkOutput("holdAddAAfterDone", add_A, expA);
        checkOutput("noStartAfterDone", add_start, 0);
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        op_a       = '0;
        op_b       = '0;
        op_sub     = 1'b0;
        adder_done = 1'b0;

        repeat (2) @(negedge CLOCK_50);
        checkOutput("rstReady", in_ready, 1);
        checkOutput("rstStart", add_start, 0);
        checkOutput("rstAddA", add_A, 0);
        checkOutput("rstAddB", add_B, 0);
        checkOutput("rstResExp", res_exp, 0);
        checkOutput("rstSpecial", special, 0);
        rst_n = 1'b1;

        // 1.0 + 2.0 : swap, d=1
        applyStimulus(16'h3C00, 16'h4000, 1'b0, 3, 14'h2000, 14'h1000, 1'b0, 1'b0, 5'd16, 1'b0, 1'b0, 1'b0);
        // 2.0 - 1.0
        applyStimulus(16'h4000, 16'h3C00, 1'b1, 3, 14'h2000, 14'h2FFF, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0);
        // 1.0 - 2.0 : swapped subtract gives negative result
        applyStimulus(16'h3C00, 16'h4000, 1'b1, 3, 14'h2000, 14'h2FFF, 1'b1, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0);
        // d=9 : three shift cycles, second request during WAIT is refused
        applyStimulus(16'h4800, 16'h2400, 1'b0, 5, 14'h2000, 14'h0010, 1'b0, 1'b0, 5'd18, 1'b0, 1'b0, 1'b1);
        // d=5 with a low mantissa bit that must survive as sticky
        applyStimulus(16'h4800, 16'h3401, 1'b0, 4, 14'h2000, 14'h0101, 1'b0, 1'b0, 5'd18, 1'b0, 1'b0, 1'b0);
        // denormal with gap >= DW collapses to sticky only
        applyStimulus(16'h3C00, 16'h0001, 1'b0, 2, 14'h2000, 14'h0001, 1'b0, 1'b0, 5'd15, 1'b0, 1'b0, 1'b0);
        // exact cancellation
        applyStimulus(16'h3C00, 16'h3C00, 1'b1, 2, 14'h2000, 14'h1FFF, 1'b1, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0);
        // Inf operand flags special
        applyStimulus(16'h7C00, 16'h3C00, 1'b0, 2, 14'h2000, 14'h0001, 1'b0, 1'b0, 5'd31, 1'b0, 1'b1, 1'b0);

        // Reset in the first SHIFT cycle of a d=9 pair
        @(negedge CLOCK_50);
        in_valid = 1'b1;
        op_a     = 16'h4800;
        op_b     = 16'h2400;
        op_sub   = 1'b0;
        @(posedge CLOCK_50);
        #1 in_valid = 1'b0;
        @(posedge CLOCK_50);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midRstReady", in_ready, 1);
        checkOutput("midRstStart", add_start, 0);
        checkOutput("midRstResExp", res_exp, 0);
        checkOutput("midRstAddA", add_A, 0);
        checkOutput("midRstAddB", add_B, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK_50);
            checkOutput("midRstNoStart", add_start, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLOCK_50);
            checkOutput("postRstNoStart", add_start, 0);
        end
        applyStimulus(16'h3C00, 16'h4000, 1'b0, 3, 14'h2000, 14'h1000, 1'b0, 1'b0, 5'd16, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/fp_align_stage.md
# fp_align_stage

Operand-alignment front end for the FPU add path. It accepts two IEEE-style operands plus an add/sub command and unpacks them. It swaps them so the larger magnitude is first, then right-shifts the smaller mantissa by the exponent difference (SHIFT_STEP bits per cycle, with a sticky bit). It then issues a single start pulse with aligned A/B/Cin to the downstream digit-serial adder, which is instantiated by the parent with N = DW, and holds the result metadata until that adder reports done.

## Interface
- EXP_W, 5, exponent field width
- MAN_W, 10, stored mantissa field width
- SHIFT_STEP, 4, max right-shift bits per SHIFT cycle
- DW (localparam), MAN_W+4, aligned datapath width: hidden bit + mantissa + guard/round/sticky

Ports:
- CLOCK_50  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  block idle, can accept
- op_a, op_b  in  EXP_W+MAN_W+1  packed sign/exp/mantissa
- op_sub  in  1  1 = a−b, 0 = a+b
- add_start  out  1  one-cycle start pulse to adder
- add_A, add_B  out  DW  aligned operands; add_B pre-inverted on effective subtract
- add_Cin  out  1  1 on effective subtract
- adder_done  in  1  done pulse from adder
- res_sign  out  1  result sign
- res_exp  out  EXP_W  larger operand's effective exponent
- eff_sub  out  1  effective subtraction
- special  out  1  either operand has exp field all-ones (Inf/NaN); downstream overrides

## Operation
- States: IDLE, COMPARE, SHIFT, ISSUE, WAIT.
- in_ready = (state==IDLE). An accept happens when in_valid && in_ready. On accept, latch op_a, op_b and op_sub, then go to COMPARE.
- **Unpack:** exp field 0 means effective exp 1 and hidden bit 0; otherwise the hidden bit is 1. The mantissa vector is {hidden, man, 3'b000}.
- **COMPARE:**
  - Compute the sign of b as sign_b^op_sub.
  - Larger operand L is the one with the larger exp; on equal exp, the larger mantissa; on a full tie, L = a.
  - d = expL−expS, eff_sub = sign_a^sign_b^op_sub.
  - res_sign = sign of L, except an exact-magnitude tie with eff_sub gives res_sign=0.
  - If d==0, go to ISSUE. If d≥DW, set small mantissa = {DW-1 zeros, |mantissa} and go to ISSUE. Otherwise go to SHIFT.
- **SHIFT:**
  - Each cycle, shift right by min(SHIFT_STEP, remaining) bits.
  - Bits shifted out are ORed into the LSB (sticky).
  - Decrement remaining by the step. Exit to ISSUE when remaining reaches 0.
- **ISSUE:**
  - add_start=1 for exactly this cycle.
  - add_A = L mantissa. add_B = S mantissa, or ~S mantissa if eff_sub. add_Cin = eff_sub.
  - Go to WAIT.
- **WAIT:**
  - add_A, add_B, add_Cin, res_* and special stay stable.
  - On adder_done, go to IDLE next cycle. An adder_done seen in any other state is ignored.
- Equal-magnitude subtract yields A + ~A + 1, i.e. zero with Cout=1. This is correct by construction.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, all registered outputs 0 (add_start, add_A, add_B, add_Cin, res_sign, res_exp, eff_sub, special). in_ready=1 once in IDLE.
- Reset mid-operation aborts immediately. No add_start pulse is issued for the aborted pair.
- Accept in cycle T. add_start fires at T+2+ceil(d/SHIFT_STEP) for 0<d<DW, and at T+2 for d==0 or d≥DW.
- add_start never fires twice per accept and never fires outside ISSUE.
- in_ready returns to 1 the cycle after adder_done is sampled in WAIT. Throughput = align latency + adder latency + 1.
- Outputs change only on accept→COMPARE→ISSUE. They are valid from the ISSUE cycle until the next accept.

## Structure
- Shared package fpu_pkg:
  - EXP_W/MAN_W defaults
  - DW and GRS_W=3 constants
  - the align state encoding
  - an exp-all-ones helper constant
- One sub-module: sticky_right_shifter. It is combinational: a shift by 0..SHIFT_STEP bits with sticky OR into the LSB, and is used once per SHIFT cycle.
- Control FSM, swap/compare and output registers live in fp_align_stage.

## Test plan
- 1.0+2.0: op_a=0x3C00, op_b=0x4000, op_sub=0 -> add_A=0x2000, add_B=0x1000, add_Cin=0, res_exp=16, res_sign=0, eff_sub=0. add_start at T+3 (swap exercised).
- 2.0−1.0: op_a=0x4000, op_b=0x3C00, op_sub=1 -> add_A=0x2000, add_B=0x2FFF, add_Cin=1, eff_sub=1, res_sign=0.
- Multi-step shift: op_a=0x4800, op_b=0x2400 (d=9) -> add_B=0x0010, exactly 3 SHIFT cycles, add_start at T+5. A second in_valid during WAIT is not accepted.
- Huge gap: op_a=0x3C00, op_b=0x0001 (denormal, d=14≥DW) -> add_B=0x0001 (sticky only), add_start at T+2.
- Exact cancel: op_a=op_b=0x3C00, op_sub=1 -> add_A=0x2000, add_B=0x1FFF, add_Cin=1, res_sign=0. A 0x7C00 operand instead -> special=1.
- Reset mid-SHIFT: d=9, drop rst_n in the first SHIFT cycle -> all outputs 0 in that cycle, no add_start. in_ready=1 after release, and a fresh pair then aligns correctly.
